// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO management target: decodes frames for PHY_ADDR, serves a 32 x 16 register
// file and returns read data on mdio_out/mdio_oen. MDC/MDIO are oversampled on clkin_50.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] STATUS_BASE  = 16'h7949,
    parameter logic [15:0] CTRL_DEFAULT = 16'h1140
) (
    input  logic        clkin_50,
    input  logic        reset,
    input  logic        mdc_in,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    localparam int unsigned     PreW   = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PreW-1:0] PreMax = PreW'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        StIdle, StSt, StOp, StPhy, StReg, StTa, StWrData, StRdData
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      mdc_sync_q;
    logic [1:0]      mdio_sync_q;
    logic            bit_en, bit_val;
    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic [4:0]      reg_q, reg_d;
    logic            match_q, match_d;
    logic            rd_q, rd_d;
    logic            oen_q, oen_d;
    logic            out_q, out_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic [14:0]     ctrl_q;
    logic [15:0]     regs_q [4:31];
    logic [15:0]     rd_value;
    logic [15:0]     wr_word;

    assign bit_en  = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign bit_val = mdio_sync_q[1];
    assign wr_word = {shift_q[14:0], bit_val};

    // Reg 0 bit 15 (soft reset) is self-clearing, so only bits 14:0 are stored.
    always_comb begin
        rd_value = 16'h0000;
        case (reg_q)
            5'd0:    rd_value = {1'b0, ctrl_q};
            5'd1: begin
                rd_value    = STATUS_BASE;
                rd_value[2] = link_up;
            end
            5'd2:    rd_value = PHY_ID1;
            5'd3:    rd_value = PHY_ID2;
            default: rd_value = regs_q[reg_q];
        endcase
    end

    always_ff @(posedge clkin_50) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            unique case (state_q)
                StIdle:   if (!bit_val && pre_cnt_q == PreMax) state_d = StSt;
                StSt:     state_d = bit_val ? StOp : StIdle;
                StOp:     if (bit_cnt_q == 5'd1) state_d = (shift_q[0] ^ bit_val) ? StPhy : StIdle;
                StPhy:    if (bit_cnt_q == 5'd4) state_d = StReg;
                StReg:    if (bit_cnt_q == 5'd4) state_d = StTa;
                StTa: begin
                    if (rd_q) begin
                        state_d = StRdData;
                    end else if (bit_cnt_q == 5'd1) begin
                        state_d = (shift_q[0] && !bit_val) ? StWrData : StIdle;
                    end
                end
                StWrData: if (bit_cnt_q == 5'd15) state_d = StIdle;
                StRdData: if (bit_cnt_q == 5'd16) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        reg_d       = reg_q;
        match_d     = match_q;
        rd_d        = rd_q;
        oen_d       = oen_q;
        out_d       = out_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (bit_en) begin
            shift_d   = wr_word;
            bit_cnt_d = (state_d != state_q) ? 5'd0 : bit_cnt_q + 5'd1;
            unique case (state_q)
                StIdle: begin
                    if (!bit_val) begin
                        pre_cnt_d = '0;
                    end else if (pre_cnt_q != PreMax) begin
                        pre_cnt_d = pre_cnt_q + PreW'(1);
                    end
                end
                StOp: if (bit_cnt_q == 5'd1) rd_d = shift_q[0] & ~bit_val;
                StReg: begin
                    if (bit_cnt_q == 5'd4) begin
                        reg_d   = wr_word[4:0];
                        match_d = (shift_q[8:4] == PHY_ADDR);
                    end
                end
                StTa: begin
                    // First TA edge of a read: latch data and start driving TA-2 low.
                    if (rd_q) begin
                        shift_d = rd_value;
                        if (match_q) begin
                            oen_d = 1'b0;
                            out_d = 1'b0;
                        end
                    end
                end
                StWrData: begin
                    if (bit_cnt_q == 5'd15 && match_q && (reg_q == 5'd0 || reg_q >= 5'd4)) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = reg_q;
                        wr_data_d   = wr_word;
                    end
                end
                StRdData: begin
                    if (bit_cnt_q != 5'd16) begin
                        out_d   = match_q & shift_q[15];
                        shift_d = {shift_q[14:0], 1'b0};
                    end
                end
                default: ;
            endcase
            if (state_d == StIdle) begin
                oen_d = 1'b1;
                out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clkin_50) begin
        if (reset) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            reg_q       <= '0;
            match_q     <= 1'b0;
            rd_q        <= 1'b0;
            oen_q       <= 1'b1;
            out_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[1:0], mdc_in};
            mdio_sync_q <= {mdio_sync_q[0], mdio_in};
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            reg_q       <= reg_d;
            match_q     <= match_d;
            rd_q        <= rd_d;
            oen_q       <= oen_d;
            out_q       <= out_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clkin_50) begin
        if (reset) begin
            ctrl_q <= CTRL_DEFAULT[14:0];
            for (int i = 4; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_strobe_d) begin
            if (wr_addr_d == 5'd0) begin
                ctrl_q <= wr_data_d[15] ? CTRL_DEFAULT[14:0] : wr_data_d[14:0];
                if (wr_data_d[15]) begin
                    for (int i = 4; i < 32; i++) regs_q[i] <= '0;
                end
            end else begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    always_comb begin
        mdio_out  = out_q;
        mdio_oen  = oen_q;
        wr_strobe = wr_strobe_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: an MDIO master task issues frames, a register
// model predicts strobes and read-back bits into queues, and monitors pop and compare them.
module tb_mdio_phy_responder;

    localparam int         HALF    = 5;
    localparam logic [4:0] PhyAddr = 5'd0;

    logic        clkin_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        mdc_in   = 1'b0;
    logic        mdio_m   = 1'b1;
    logic        link_up  = 1'b0;
    logic        mdio_in, mdio_out, mdio_oen, wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    assign mdio_in = mdio_oen ? mdio_m : mdio_out;

    always #10 clkin_50 = ~clkin_50;

    mdio_phy_responder #(
        .PHY_ADDR(PhyAddr)
    ) dut (
        .clkin_50 (clkin_50),
        .reset    (reset),
        .mdc_in   (mdc_in),
        .mdio_in  (mdio_in),
        .mdio_out (mdio_out),
        .mdio_oen (mdio_oen),
        .link_up  (link_up),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    typedef struct {int n; logic [16:0] v;} rd_exp_t;
    typedef struct {logic [4:0] a; logic [15:0] d;} wr_exp_t;

    rd_exp_t     rd_exp_q[$];
    wr_exp_t     wr_exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_ctrl;
    logic [15:0] m_regs [32];
    logic [16:0] mon_bits = '0;
    int          mon_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 16'h1140;
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'd0:    return m_ctrl & 16'h7FFF;
            5'd1:    return (16'h7949 & ~16'h0004) | (link_up ? 16'h0004 : 16'h0000);
            5'd2:    return 16'h0141;
            5'd3:    return 16'h0CC2;
            default: return m_regs[a];
        endcase
    endfunction

    // Read monitor: collect what the master samples while the DUT drives, compare on release.
    always @(posedge mdc_in) begin
        if (mdio_oen === 1'b0) begin
            mon_bits = {mon_bits[15:0], mdio_out};
            mon_n++;
        end
    end

    always @(posedge mdio_oen) begin
        if (mon_n > 0) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected drive: got %0d bits %h expected none", mon_n, mon_bits);
            end else begin
                rd_exp_t e;
                e = rd_exp_q.pop_front();
                check("read bit count", mon_n, e.n);
                check("read bits", 32'(mon_bits), 32'(e.v));
            end
            mon_bits = '0;
            mon_n    = 0;
        end
    end

    always @(negedge clkin_50) begin
        if (wr_strobe === 1'b1) begin
            if (wr_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected wr_strobe: got addr %0d data %h expected none",
                         wr_addr, wr_data);
            end else begin
                wr_exp_t e;
                e = wr_exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    task automatic mdc_cycle(input logic v, input bit do_rst);
        mdio_m = v;
        repeat (HALF) @(negedge clkin_50);
        mdc_in = 1'b1;
        if (do_rst) begin
            @(negedge clkin_50);
            reset = 1'b1;
            @(negedge clkin_50);
            check("oen after mid-read reset", 32'(mdio_oen), 32'd1);
            check("out after mid-read reset", 32'(mdio_out), 32'd0);
            check("strobe after mid-read reset", 32'(wr_strobe), 32'd0);
            reset = 1'b0;
            repeat (HALF - 2) @(negedge clkin_50);
        end else begin
            repeat (HALF) @(negedge clkin_50);
        end
        mdc_in = 1'b0;
    endtask

    task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] data,
                            input int rst_at);
        logic        bq[$];
        logic [15:0] rv;
        rd_exp_t     re;
        wr_exp_t     we;
        bit          ok;
        ok = (pre >= 32) && (phy == PhyAddr);
        if (ok && op == 2'b10) begin
            rv   = model_read(ra);
            re.n = (rst_at >= 0) ? 9 : 17;
            re.v = (rst_at >= 0) ? {8'h00, 1'b0, rv[15:8]} : {1'b0, rv};
            rd_exp_q.push_back(re);
        end
        if (ok && op == 2'b01 && ta == 2'b10 && (ra == 5'd0 || ra >= 5'd4)) begin
            we.a = ra;
            we.d = data;
            wr_exp_q.push_back(we);
            if (ra == 5'd0 && data[15]) model_reset();
            else if (ra == 5'd0) m_ctrl = data;
            else m_regs[ra] = data;
        end
        bq.push_back(1'b0);
        repeat (pre) bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        bq.push_back(op[1]);
        bq.push_back(op[0]);
        for (int i = 4; i >= 0; i--) bq.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) bq.push_back(ra[i]);
        if (op == 2'b10) begin
            repeat (18) bq.push_back(1'b1);
        end else begin
            bq.push_back(ta[1]);
            bq.push_back(ta[0]);
            for (int i = 15; i >= 0; i--) bq.push_back(data[i]);
        end
        for (int i = 0; i < bq.size(); i++) mdc_cycle(bq[i], i == rst_at);
        mdio_m = 1'b1;
        if (rst_at >= 0) model_reset();
        repeat (4) @(negedge clkin_50);
    endtask

    initial begin
        int          pre, r;
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;
        logic [15:0] data;
        model_reset();
        repeat (4) @(negedge clkin_50);
        check("reset mdio_oen", 32'(mdio_oen), 32'd1);
        check("reset mdio_out", 32'(mdio_out), 32'd0);
        check("reset wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clkin_50);

        do_frame(32, 2'b01, PhyAddr, 5'd4, 2'b10, 16'hA5C3, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd4, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd2, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd3, 2'b10, 16'h0000, -1);
        link_up = 1'b1;
        do_frame(32, 2'b10, PhyAddr, 5'd1, 2'b10, 16'h0000, -1);
        link_up = 1'b0;
        do_frame(32, 2'b10, PhyAddr, 5'd1, 2'b10, 16'h0000, -1);
        do_frame(31, 2'b01, PhyAddr, 5'd4, 2'b10, 16'hFFFF, -1);
        do_frame(31, 2'b10, PhyAddr, 5'd4, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b01, PhyAddr + 5'd1, 5'd4, 2'b10, 16'h0F0F, -1);
        do_frame(32, 2'b10, PhyAddr + 5'd1, 5'd4, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd4, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b01, PhyAddr, 5'd2, 2'b10, 16'hBEEF, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd2, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b01, PhyAddr, 5'd4, 2'b10, 16'h1234, -1);
        do_frame(32, 2'b01, PhyAddr, 5'd0, 2'b10, 16'h8000, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd0, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd4, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b01, PhyAddr, 5'd5, 2'b11, 16'h5555, -1);
        do_frame(32, 2'b11, PhyAddr, 5'd5, 2'b10, 16'h6666, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd5, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b01, PhyAddr, 5'd6, 2'b10, 16'hC3A5, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd6, 2'b10, 16'h0000, 32 + 24);
        do_frame(32, 2'b10, PhyAddr, 5'd0, 2'b10, 16'h0000, -1);
        do_frame(32, 2'b10, PhyAddr, 5'd6, 2'b10, 16'h0000, -1);

        for (int n = 0; n < 30; n++) begin
            pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + int'($urandom_range(0, 3));
            r   = int'($urandom_range(0, 9));
            op  = (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : (r[0] ? 2'b11 : 2'b00);
            phy = ($urandom_range(0, 7) == 0) ? 5'(PhyAddr + 5'(1 + $urandom_range(0, 30)))
                                              : PhyAddr;
            ra  = $urandom_range(0, 1) ? 5'($urandom_range(0, 6)) : 5'($urandom_range(0, 31));
            ta  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            data = 16'($urandom);
            if (ra == 5'd0 && $urandom_range(0, 3) != 0) data[15] = 1'b0;
            link_up = 1'($urandom_range(0, 1));
            do_frame(pre, op, phy, ra, ta, data, -1);
        end

        repeat (20) @(negedge clkin_50);
        check("read expectations drained", 32'(rd_exp_q.size()), 32'd0);
        check("write expectations drained", 32'(wr_exp_q.size()), 32'd0);
        check("idle mdio_oen", 32'(mdio_oen), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
